// File: rtl/ccff_bitstream_loader_if.sv
// Valid/ready word stream from the bitstream source into the chain loader.
interface ccff_bitstream_loader_if #(
  parameter int WORD_W = 8
);
  logic [WORD_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/ccff_bitstream_loader.sv
// Shifts configuration words MSB-first into the fabric chain head, with an
// optional second pass that re-shifts the same stream and compares the tail.
//
// state  | meaning
// IDLE   | waiting for start; stream not accepted
// LOAD   | first pass, CHAIN_LEN bits into the chain
// VERIFY | second pass, tail compared against head on every shift
// DONE   | one-cycle completion, done pulse and verify_pass valid
module ccff_bitstream_loader #(
  parameter int CHAIN_LEN = 1024,
  parameter int WORD_W    = 8,
  parameter int CNT_W     = 16
) (
  input  logic                   prog_clk,
  input  logic                   pReset,
  input  logic                   start,
  input  logic                   verify_en,
  ccff_bitstream_loader_if.slave s_if,
  output logic                   ccff_head,
  output logic                   ccff_shift,
  input  logic                   ccff_tail,
  output logic                   busy,
  output logic                   done,
  output logic [CNT_W-1:0]       mismatch_cnt,
  output logic                   verify_pass
);
  localparam int BIT_W = $clog2(CHAIN_LEN + 1);
  localparam int BUF_W = $clog2(WORD_W + 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(CHAIN_LEN - 1);
  localparam logic [BIT_W-1:0] FULL_PASS = BIT_W'(CHAIN_LEN);
  localparam logic [BUF_W-1:0] WORD_BITS = BUF_W'(WORD_W);

  typedef enum logic [1:0] {IDLE, LOAD, VERIFY, DONE} state_t;

  state_t             state;
  logic [BIT_W-1:0]   bit_cnt;
  logic [BUF_W-1:0]   buf_cnt;
  logic [WORD_W-1:0]  shift_buf;
  logic               verify_latched;
  logic               shift_vfy;

  logic               active;
  logic               pass_open;
  logic               shift_now;
  logic               final_shift;
  logic               need_more;
  logic               buf_free;
  logic               ready_int;
  logic               accept;
  logic               mm_hit;
  logic [CNT_W-1:0]   mm_next;
  logic [31:0]        bits_committed;

  // Stream handshake, shift qualification and next mismatch count.
  always_comb begin
    active         = (state == LOAD) || (state == VERIFY);
    pass_open      = bit_cnt < FULL_PASS;
    shift_now      = active && pass_open && (buf_cnt != '0);
    final_shift    = shift_now && (bit_cnt == LAST_BIT);
    // Shifted plus buffered bits; once this reaches CHAIN_LEN the pass
    // needs no further words and leftover buffer bits are dropped.
    bits_committed = 32'(bit_cnt) + 32'(buf_cnt);
    need_more      = bits_committed < 32'(CHAIN_LEN);
    buf_free       = (buf_cnt == '0) || (shift_now && (buf_cnt == BUF_W'(1)));
    // The last LOAD shift may overlap the first VERIFY word accept.
    ready_int      = active && ((need_more && buf_free) ||
                                (final_shift && (state == LOAD) && verify_latched));
    accept         = ready_int && s_if.s_valid;
    mm_hit         = ccff_shift && shift_vfy && (ccff_tail != ccff_head);
    mm_next        = mismatch_cnt;
    if (mm_hit && (mismatch_cnt != '1)) mm_next = mismatch_cnt + CNT_W'(1);
  end

  assign s_if.s_ready = ready_int;

  // Sequencer, shift buffer, chain outputs and verify bookkeeping.
  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      state          <= IDLE;
      bit_cnt        <= '0;
      buf_cnt        <= '0;
      shift_buf      <= '0;
      verify_latched <= 1'b0;
      shift_vfy      <= 1'b0;
      ccff_head      <= 1'b0;
      ccff_shift     <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      mismatch_cnt   <= '0;
      verify_pass    <= 1'b0;
    end else begin
      ccff_shift <= 1'b0;
      done       <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state          <= LOAD;
            verify_latched <= verify_en;
            mismatch_cnt   <= '0;
            verify_pass    <= 1'b0;
            bit_cnt        <= '0;
            buf_cnt        <= '0;
            busy           <= 1'b1;
          end
        end
        LOAD, VERIFY: begin
          mismatch_cnt <= mm_next;
          if (shift_now) begin
            ccff_head  <= shift_buf[WORD_W-1];
            ccff_shift <= 1'b1;
            // Tags the shift so the compare happens when it reaches the chain.
            shift_vfy  <= (state == VERIFY);
            shift_buf  <= shift_buf << 1;
            buf_cnt    <= buf_cnt - BUF_W'(1);
            bit_cnt    <= bit_cnt + BIT_W'(1);
          end
          if (accept) begin
            shift_buf <= s_if.s_data;
            buf_cnt   <= WORD_BITS;
          end
          if (final_shift) begin
            if (!accept) buf_cnt <= '0;
            if ((state == LOAD) && verify_latched) begin
              state   <= VERIFY;
              bit_cnt <= '0;
            end
          end
          // One drain cycle lets the last shift reach the chain (and be
          // compared) before the sequence reports completion.
          if (!pass_open) begin
            state       <= DONE;
            bit_cnt     <= '0;
            busy        <= 1'b0;
            done        <= 1'b1;
            verify_pass <= verify_latched && (mm_next == '0);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Bench for the chain loader: table-driven sequences, randomized verify runs
// against a bit-stream model, reset mid-load, and a short-chain instance.
`timescale 1ns/1ps
module tb_ccff_bitstream_loader;
  localparam int CL = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1;

  logic        st16 = 1'b0, ve16 = 1'b0, stuck16 = 1'b0;
  logic        head16, shift16, tail16, busy16, done16, vp16;
  logic [15:0] mm16;
  logic [CL-1:0] chain16 = '0;

  logic        st10 = 1'b0, ve10 = 1'b0;
  logic        head10, shift10, busy10, done10, vp10;
  logic [2:0]  mm10;

  ccff_bitstream_loader_if #(.WORD_W(8)) if16 ();
  ccff_bitstream_loader_if #(.WORD_W(8)) if10 ();

  ccff_bitstream_loader #(.CHAIN_LEN(CL), .WORD_W(8), .CNT_W(16)) u_dut16 (
    .prog_clk(clk), .pReset(rst), .start(st16), .verify_en(ve16), .s_if(if16),
    .ccff_head(head16), .ccff_shift(shift16), .ccff_tail(tail16), .busy(busy16),
    .done(done16), .mismatch_cnt(mm16), .verify_pass(vp16));

  ccff_bitstream_loader #(.CHAIN_LEN(10), .WORD_W(8), .CNT_W(3)) u_dut10 (
    .prog_clk(clk), .pReset(rst), .start(st10), .verify_en(ve10), .s_if(if10),
    .ccff_head(head10), .ccff_shift(shift10), .ccff_tail(1'b0), .busy(busy10),
    .done(done10), .mismatch_cnt(mm10), .verify_pass(vp10));

  // Behavioural configuration chain; tail optionally stuck at 0.
  always @(posedge clk) if (shift16) chain16 <= {chain16[CL-2:0], head16};
  assign tail16 = stuck16 ? 1'b0 : chain16[CL-1];

  int total = 0, bad = 0;
  logic [7:0] src_q[$];
  bit got_q[$];
  bit exp_q[$];
  int first_sh, last_sh, done_cyc;

  typedef struct packed {
    bit          ven;
    bit          stuck;
    bit          poke;
    logic [1:0]  gap;
    logic [31:0] words;
    logic [2:0]  nw;
    logic [5:0]  exp_shifts;
    logic [15:0] exp_mm;
    bit          exp_vp;
    logic [15:0] exp_chain;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Expected head stream: each pass takes its words MSB-first, first clen bits.
  task automatic build_exp(input logic [31:0] words, input int nw, input bit ven, input int clen);
    int passes, wpp, n, kk;
    passes = ven ? 2 : 1;
    wpp = nw / passes;
    exp_q.delete();
    for (int p = 0; p < passes; p++) begin
      n = 0;
      for (int k = 0; k < wpp; k++) begin
        kk = p * wpp + k;
        for (int b = 7; b >= 0; b--) begin
          if (n < clen) begin
            exp_q.push_back(words[24 - 8 * kk + b]);
            n++;
          end
        end
      end
    end
  endtask

  task automatic load_src(input logic [31:0] words, input int nw);
    src_q.delete();
    for (int k = 0; k < nw; k++) src_q.push_back(words[31 - 8 * k -: 8]);
  endtask

  // gap: 0 = valid held, 1 = valid every other cycle, 2 = random valid.
  task automatic run16(input string nm, input bit ven, input int gap, input bit poke);
    bit fin, acc, offer;
    fin = 0;
    got_q.delete();
    first_sh = -1; last_sh = -1; done_cyc = -1;
    for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
      @(negedge clk);
      if (shift16) begin
        got_q.push_back(head16);
        if (first_sh < 0) first_sh = cyc;
        last_sh = cyc;
      end
      if (done16) begin done_cyc = cyc; fin = 1; end
      st16 = (cyc == 0) || (poke && cyc == 6);
      ve16 = (cyc == 0) ? ven : ~ven;
      offer = (src_q.size() > 0) &&
              (gap == 0 || (gap == 1 && cyc % 2 == 0) || (gap == 2 && $urandom_range(0, 1) == 1));
      if16.s_valid = offer;
      if16.s_data  = offer ? src_q[0] : 8'h00;
      acc = if16.s_valid && if16.s_ready;
      @(posedge clk);
      if (acc) void'(src_q.pop_front());
    end
    st16 = 1'b0;
    if16.s_valid = 1'b0;
    check({nm, "_done_seen"}, 32'(fin), 32'd1);
  endtask

  task automatic score16(input string nm, input int gap, input int es, input int em,
                         input bit ev, input logic [15:0] ec);
    int errs;
    errs = 0;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i] !== exp_q[i]) errs++;
    check({nm, "_shifts"}, got_q.size(), es);
    check({nm, "_head_bits"}, errs, 0);
    check({nm, "_done_lat"}, done_cyc - last_sh, 1);
    if (gap == 0) check({nm, "_contig"}, last_sh - first_sh + 1, es);
    check({nm, "_mismatch"}, 32'(mm16), em);
    check({nm, "_vpass"}, 32'(vp16), 32'(ev));
    check({nm, "_chain"}, 32'(chain16), 32'(ec));
    @(negedge clk);
    check({nm, "_done_width"}, 32'(done16), 32'd0);
    check({nm, "_idle_busy"}, 32'(busy16), 32'd0);
  endtask

  task automatic run10(input string nm, input bit ven, input int exp_mm, input bit exp_vp);
    int n_sh, n_ones, n_acc, late, nwords;
    bit fin, acc;
    logic [7:0] q10[$];
    n_sh = 0; n_ones = 0; n_acc = 0; late = 0; fin = 0;
    nwords = ven ? 4 : 2;
    for (int k = 0; k < nwords; k++) q10.push_back((k % 2 == 0) ? 8'hFF : 8'hC0);
    for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
      @(negedge clk);
      if (shift10) begin n_sh++; if (head10) n_ones++; end
      if (done10) fin = 1;
      if (if10.s_ready && n_acc == nwords) late++;
      st10 = (cyc == 0);
      ve10 = ven;
      if10.s_valid = q10.size() > 0;
      if10.s_data  = (q10.size() > 0) ? q10[0] : 8'h00;
      acc = if10.s_valid && if10.s_ready;
      @(posedge clk);
      if (acc) begin void'(q10.pop_front()); n_acc++; end
    end
    st10 = 1'b0;
    if10.s_valid = 1'b0;
    check({nm, "_done_seen"}, 32'(fin), 32'd1);
    check({nm, "_shifts"}, n_sh, ven ? 20 : 10);
    check({nm, "_ones"}, n_ones, ven ? 20 : 10);
    check({nm, "_accepts"}, n_acc, nwords);
    check({nm, "_late_ready"}, late, 0);
    check({nm, "_mismatch"}, 32'(mm10), exp_mm);
    check({nm, "_vpass"}, 32'(vp10), 32'(exp_vp));
  endtask

  initial begin
    vec_t vecs[5];
    logic [31:0] rw;
    int mm_e, n;
    bit acc;
    logic [15:0] ch_e;

    //          ven stk poke gap words         nw shifts mm     vp chain
    vecs[0] = '{1'b0, 1'b0, 1'b0, 2'd0, 32'hA53C0000, 3'd2, 6'd16, 16'd0, 1'b0, 16'hA53C};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 2'd0, 32'hA53CA53C, 3'd4, 6'd32, 16'd0, 1'b1, 16'hA53C};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 2'd0, 32'hFF00FF00, 3'd4, 6'd32, 16'd8, 1'b0, 16'hFF00};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 2'd1, 32'hA53C0000, 3'd2, 6'd16, 16'd0, 1'b0, 16'hA53C};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 2'd1, 32'h5AC35AC3, 3'd4, 6'd32, 16'd0, 1'b1, 16'h5AC3};

    if16.s_valid = 1'b0; if16.s_data = 8'h00;
    if10.s_valid = 1'b0; if10.s_data = 8'h00;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    if16.s_valid = 1'b1;
    @(negedge clk);
    check("rst_busy", 32'(busy16), 0);
    check("rst_done", 32'(done16), 0);
    check("rst_shift", 32'(shift16), 0);
    check("rst_head", 32'(head16), 0);
    check("rst_mm", 32'(mm16), 0);
    check("rst_vpass", 32'(vp16), 0);
    check("rst_ready", 32'(if16.s_ready), 0);
    check("rst_busy10", 32'(busy10), 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_valid_ready", 32'(if16.s_ready), 0);
    if16.s_valid = 1'b0;

    for (int i = 0; i < 5; i++) begin
      stuck16 = vecs[i].stuck;
      load_src(vecs[i].words, int'(vecs[i].nw));
      build_exp(vecs[i].words, int'(vecs[i].nw), vecs[i].ven, CL);
      run16($sformatf("vec%0d", i), vecs[i].ven, int'(vecs[i].gap), vecs[i].poke);
      score16($sformatf("vec%0d", i), int'(vecs[i].gap), int'(vecs[i].exp_shifts),
              int'(vecs[i].exp_mm), vecs[i].exp_vp, vecs[i].exp_chain);
    end
    stuck16 = 1'b0;

    // Randomized load/verify streams; mismatches equal the Hamming distance
    // between the two passes since the tail replays the loaded bits.
    for (int r = 0; r < 6; r++) begin
      rw = $urandom;
      load_src(rw, 4);
      build_exp(rw, 4, 1'b1, CL);
      mm_e = 0;
      for (int i = 0; i < CL; i++) begin
        if (exp_q[i] != exp_q[CL + i]) mm_e++;
        ch_e[CL - 1 - i] = exp_q[CL + i];
      end
      run16($sformatf("rnd%0d", r), 1'b1, 2, 1'b0);
      score16($sformatf("rnd%0d", r), 2, 2 * CL, mm_e, mm_e == 0, ch_e);
    end

    // Reset after five shifts, then a clean reload.
    load_src(32'h12340000, 2);
    n = 0;
    for (int cyc = 0; cyc < 60 && n < 5; cyc++) begin
      @(negedge clk);
      if (shift16) n++;
      st16 = (cyc == 0);
      ve16 = 1'b0;
      if16.s_valid = src_q.size() > 0;
      if16.s_data  = (src_q.size() > 0) ? src_q[0] : 8'h00;
      acc = if16.s_valid && if16.s_ready;
      @(posedge clk);
      if (acc) void'(src_q.pop_front());
    end
    st16 = 1'b0;
    check("mid_reached", n, 5);
    @(negedge clk);
    rst = 1'b1;
    if16.s_valid = 1'b1;
    @(negedge clk);
    check("mid_rst_busy", 32'(busy16), 0);
    check("mid_rst_ready", 32'(if16.s_ready), 0);
    check("mid_rst_shift", 32'(shift16), 0);
    rst = 1'b0;
    if16.s_valid = 1'b0;
    load_src(32'hC33C0000, 2);
    build_exp(32'hC33C0000, 2, 1'b0, CL);
    run16("reload", 1'b0, 0, 1'b0);
    score16("reload", 0, CL, 0, 1'b0, 16'hC33C);

    // Ten-bit chain: partial last word, saturating 3-bit counter, tail stuck 0.
    run10("c10_load", 1'b0, 0, 1'b0);
    run10("c10_verify", 1'b1, 7, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
